// File: rtl/tc_accumulator_if.sv
// ---------------------------------------------------------------------------
// tc_accumulator_if
//   Bundles the partial-tile input, the status flags and the output-tile
//   valid/ready channel of the tensor-core accumulator.
//
//   Handshake: the input side is a pulse protocol.
//     - Each cycle with in_valid=1 delivers one partial tile.
//     - There is no ready on the input side. The producer must watch stall.
//   The output side is strict valid/ready.
//     - A head tile transfers on every rising edge where out_valid and
//       out_ready are both 1.
//     - Once out_valid is raised, the head tile stays stable until it is
//       taken.
//
//   Signals
//     in_valid, in_c0..in_c3      partial tile from the tensor core
//     stall, busy, drop_err       accumulator status
//     out_valid, out_ready        output tile handshake
//     out_d0..out_d3, out_sat     head tile of the output FIFO
//
//   Modports
//     master : producer/consumer side (testbench, core + writeback)
//     slave  : the accumulator itself
// ---------------------------------------------------------------------------
interface tc_accumulator_if #(
    parameter int IN_W  = 32,
    parameter int ACC_W = 40
);
    logic             in_valid;
    logic [IN_W-1:0]  in_c0;
    logic [IN_W-1:0]  in_c1;
    logic [IN_W-1:0]  in_c2;
    logic [IN_W-1:0]  in_c3;
    logic             stall;
    logic             busy;
    logic             drop_err;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_d0;
    logic [ACC_W-1:0] out_d1;
    logic [ACC_W-1:0] out_d2;
    logic [ACC_W-1:0] out_d3;
    logic             out_sat;

    modport master (
        output in_valid, in_c0, in_c1, in_c2, in_c3, out_ready,
        input  stall, busy, drop_err, out_valid,
               out_d0, out_d1, out_d2, out_d3, out_sat
    );

    modport slave (
        input  in_valid, in_c0, in_c1, in_c2, in_c3, out_ready,
        output stall, busy, drop_err, out_valid,
               out_d0, out_d1, out_d2, out_d3, out_sat
    );
endinterface

// File: rtl/tc_accumulator.sv
// ---------------------------------------------------------------------------
// tc_accumulator
//   Sums K_STEPS consecutive 2x2 partial-product tiles from the tensor core
//   into one output tile.
//   - Each element is summed separately and saturates at 2^ACC_W-1.
//   - Completed tiles are queued in an OUT_DEPTH-entry FIFO.
//   - The FIFO drains to writeback over valid/ready.
//   - A completed tile that cannot be queued is parked in the accumulators
//     (HOLD state), and stall is raised until it can be queued.
//
//   Ports
//     clk        clock
//     rst_n      asynchronous active-low reset
//     clear      synchronous abort of the accumulation in progress
//                (the FIFO is not touched)
//     acc_if     tile input, status flags and output handshake
//                (slave modport)
//     state_dbg  current FSM state (0=IDLE, 1=ACCUM, 2=HOLD)
// ---------------------------------------------------------------------------
module tc_accumulator #(
    parameter int IN_W      = 32,
    parameter int ACC_W     = 40,
    parameter int K_STEPS   = 4,
    parameter int OUT_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    tc_accumulator_if.slave    acc_if,
    output logic [1:0]         state_dbg
);

    localparam int STEP_W = (K_STEPS > 1) ? $clog2(K_STEPS) : 1;
    localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W  = $clog2(OUT_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t              state, state_nxt;
    logic [STEP_W-1:0]   step, step_nxt;
    logic [ACC_W-1:0]    acc      [4];
    logic [ACC_W-1:0]    acc_nxt  [4];
    logic                sat, sat_nxt;
    logic                drop_err_q;
    logic                drop_set;

    logic [IN_W-1:0]     in_c     [4];
    logic [ACC_W-1:0]    in_ext   [4];
    logic [ACC_W:0]      wide_sum [4];
    logic [ACC_W-1:0]    sum_sat  [4];
    logic [3:0]          ovf;
    logic                last_step;

    logic [ACC_W-1:0]    tile_d   [4];
    logic                tile_sat;
    logic                complete;

    logic                push, pop, space, full;
    logic [ACC_W-1:0]    push_d   [4];
    logic                push_sat;

    logic [4*ACC_W-1:0]  mem_d    [OUT_DEPTH];
    logic                mem_sat  [OUT_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [4*ACC_W-1:0]  head;

    // ------------------------------------------------------------------
    // Per-element saturating adder
    // ------------------------------------------------------------------
    assign in_c[0] = acc_if.in_c0;
    assign in_c[1] = acc_if.in_c1;
    assign in_c[2] = acc_if.in_c2;
    assign in_c[3] = acc_if.in_c3;

    // One guard bit above ACC_W catches the carry-out. On overflow the
    // element is pinned at all-ones rather than wrapping.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_ext[i]   = ACC_W'(in_c[i]);
            wide_sum[i] = {1'b0, acc[i]} + {1'b0, in_ext[i]};
            ovf[i]      = wide_sum[i][ACC_W];
            sum_sat[i]  = wide_sum[i][ACC_W] ? {ACC_W{1'b1}} : wide_sum[i][ACC_W-1:0];
        end
    end

    assign last_step = (step == STEP_W'(K_STEPS - 1));

    // ------------------------------------------------------------------
    // FIFO status used by the commit decision
    // ------------------------------------------------------------------
    assign full  = (count == CNT_W'(OUT_DEPTH));
    assign pop   = acc_if.out_valid & acc_if.out_ready;
    // A pop in the same cycle frees the slot the push will use.
    assign space = !full || pop;

    // ------------------------------------------------------------------
    // FSM next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        sat_nxt   = sat;
        drop_set  = 1'b0;
        complete  = 1'b0;
        tile_sat  = 1'b0;
        push      = 1'b0;
        push_sat  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            acc_nxt[i] = acc[i];
            tile_d[i]  = sum_sat[i];
            push_d[i]  = '0;
        end

        if (clear) begin
            // Abort beats everything, including a same-cycle input and a
            // held tile. No error is flagged for the input lost here.
            state_nxt = IDLE;
            step_nxt  = '0;
            sat_nxt   = 1'b0;
            for (int i = 0; i < 4; i++) acc_nxt[i] = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (acc_if.in_valid) begin
                        // The first tile loads directly and cannot overflow
                        // because ACC_W >= IN_W.
                        for (int i = 0; i < 4; i++) tile_d[i] = in_ext[i];
                        tile_sat = 1'b0;
                        if (K_STEPS == 1) begin
                            complete = 1'b1;
                        end else begin
                            for (int i = 0; i < 4; i++) acc_nxt[i] = in_ext[i];
                            step_nxt  = STEP_W'(1);
                            state_nxt = ACCUM;
                        end
                    end
                end

                ACCUM: begin
                    if (acc_if.in_valid) begin
                        tile_sat = sat | (|ovf);
                        if (last_step) begin
                            complete = 1'b1;
                        end else begin
                            for (int i = 0; i < 4; i++) acc_nxt[i] = sum_sat[i];
                            sat_nxt  = tile_sat;
                            step_nxt = step + 1'b1;
                        end
                    end
                end

                HOLD: begin
                    if (acc_if.in_valid) drop_set = 1'b1;
                    if (space) begin
                        push     = 1'b1;
                        push_sat = sat;
                        for (int i = 0; i < 4; i++) begin
                            push_d[i]  = acc[i];
                            acc_nxt[i] = '0;
                        end
                        sat_nxt   = 1'b0;
                        step_nxt  = '0;
                        state_nxt = IDLE;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase

            // A tile just finished: queue it now if possible, else park it.
            if (complete) begin
                if (space) begin
                    push     = 1'b1;
                    push_sat = tile_sat;
                    for (int i = 0; i < 4; i++) begin
                        push_d[i]  = tile_d[i];
                        acc_nxt[i] = '0;
                    end
                    sat_nxt   = 1'b0;
                    step_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    for (int i = 0; i < 4; i++) acc_nxt[i] = tile_d[i];
                    sat_nxt   = tile_sat;
                    state_nxt = HOLD;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM / accumulator registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            step       <= '0;
            sat        <= 1'b0;
            drop_err_q <= 1'b0;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
            sat   <= sat_nxt;
            for (int i = 0; i < 4; i++) acc[i] <= acc_nxt[i];
            // Sticky until reset.
            if (drop_set) drop_err_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: every read is masked by out_valid.
    // On push-while-full with pop, wr_ptr equals rd_ptr. The head is read
    // combinationally this cycle before the write lands, so both the push
    // and the pop are honoured.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_d[wr_ptr]   <= {push_d[3], push_d[2], push_d[1], push_d[0]};
            mem_sat[wr_ptr] <= push_sat;
        end
    end

    assign head = mem_d[rd_ptr];

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign acc_if.out_valid = (count != '0);
    assign acc_if.out_d0    = acc_if.out_valid ? head[0*ACC_W +: ACC_W] : '0;
    assign acc_if.out_d1    = acc_if.out_valid ? head[1*ACC_W +: ACC_W] : '0;
    assign acc_if.out_d2    = acc_if.out_valid ? head[2*ACC_W +: ACC_W] : '0;
    assign acc_if.out_d3    = acc_if.out_valid ? head[3*ACC_W +: ACC_W] : '0;
    assign acc_if.out_sat   = acc_if.out_valid & mem_sat[rd_ptr];

    // stall depends on state only, so it has no combinational path from
    // in_valid.
    assign acc_if.stall    = (state == HOLD);
    assign acc_if.busy     = (step != '0) || (state == HOLD);
    assign acc_if.drop_err = drop_err_q;
    assign state_dbg       = state;

endmodule
